// File: rtl/two_ch_readout.sv
// two_ch_readout: once armed, waits for both channel buffers to fill, then sweeps
// read_index 0..N-1. Each A/B sample pair is packed into one 32-bit word and
// streamed on a valid/ready interface, with out_last on the final word.
module two_ch_readout #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] sample_count,
  input  logic              done_A,
  input  logic              done_B,
  output logic [ADDR_W-1:0] read_index,
  input  logic [DATA_W-1:0] data_in_A,
  input  logic [DATA_W-1:0] data_in_B,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              frame_done
);

  // Latency counter runs 0..RD_LAT-1; keep it at least one bit wide.
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_ADDR,
    S_SEND,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_n;
  logic [ADDR_W-1:0] r_idx;
  logic [LAT_W-1:0]  r_lat;
  logic [31:0]       r_out_data;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_frame_done;

  // Each sample is zero-extended into its own 16-bit half of the word.
  logic [31:0]       w_word;
  logic              w_is_last;

  assign w_word    = {16'(data_in_A), 16'(data_in_B)};
  // Only consulted when N is non-zero, so N-1 never underflows here.
  assign w_is_last = (r_idx == (r_n - IDX_ONE));

  // Readout sequencer: arm, wait for both buffers, then address/send per index.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_n          <= '0;
      r_idx        <= '0;
      r_lat        <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n     <= sample_count;
            r_idx   <= '0;
            r_state <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (done_A && done_B) begin
            if (r_n == '0) begin
              r_frame_done <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_lat   <= '0;
              r_state <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          // read_index has been stable since entry; capture on the RD_LAT-th edge.
          if (r_lat == LAT_LAST) begin
            r_out_data  <= w_word;
            r_out_valid <= 1'b1;
            r_out_last  <= w_is_last;
            r_state     <= S_SEND;
          end else begin
            r_lat <= r_lat + LAT_W'(1);
          end
        end
        S_SEND: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_out_last) begin
              r_out_last   <= 1'b0;
              r_frame_done <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_idx   <= r_idx + IDX_ONE;
              r_lat   <= '0;
              r_state <= S_ADDR;
            end
          end
        end
        S_DONE: begin
          // frame_done is high for this single cycle; start here is ignored.
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign read_index = r_idx;
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign out_last   = r_out_last;
  assign frame_done = r_frame_done;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_two_ch_readout.sv
// Bench for two_ch_readout: scoreboard of expected words, directed steps.
// dut1 uses RD_LAT=1 with a combinational buffer model; dut3 uses RD_LAT=3 with a
// buffer model whose data trails read_index so an early capture reads stale data.
module tb_two_ch_readout;

  localparam int DW = 14;
  localparam int AW = 10;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          start1, start3;
  logic [AW-1:0] sample_count;
  logic          done_A, done_B;
  logic          out_ready1, out_ready3;

  logic [AW-1:0] read_index1, read_index3;
  logic [DW-1:0] data_in_A1, data_in_B1, data_in_A3, data_in_B3;
  logic [31:0]   out_data1, out_data3;
  logic          out_valid1, out_valid3, out_last1, out_last3;
  logic          busy1, busy3, frame_done1, frame_done3;

  logic [AW-1:0] ri3_d1, ri3_d2;

  exp_t q1[$];
  exp_t q3[$];
  int   total = 0;
  int   bad   = 0;
  int   xfer1 = 0;
  int   xfer3 = 0;

  two_ch_readout #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .sample_count(sample_count),
    .done_A(done_A), .done_B(done_B), .read_index(read_index1),
    .data_in_A(data_in_A1), .data_in_B(data_in_B1), .out_data(out_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_last(out_last1),
    .busy(busy1), .frame_done(frame_done1)
  );

  two_ch_readout #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .sample_count(sample_count),
    .done_A(done_A), .done_B(done_B), .read_index(read_index3),
    .data_in_A(data_in_A3), .data_in_B(data_in_B3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_last(out_last3),
    .busy(busy3), .frame_done(frame_done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer contents: A[i] = i+100, B[i] = i+200.
  assign data_in_A1 = DW'(read_index1 + 100);
  assign data_in_B1 = DW'(read_index1 + 200);

  // Three-cycle buffer for dut3: data at the capture edge reflects read_index two cycles back.
  always @(posedge clk) begin
    ri3_d1 <= read_index3;
    ri3_d2 <= ri3_d1;
  end
  assign data_in_A3 = DW'(ri3_d2 + 100);
  assign data_in_B3 = DW'(ri3_d2 + 200);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_frame(input int which, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.data = {16'(i + 100), 16'(i + 200)};
      e.last = (i == n - 1);
      if (which == 1) q1.push_back(e);
      else            q3.push_back(e);
    end
  endtask

  task automatic wait_fd(input int which, input int bound, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    for (int k = 0; k < bound && !seen; k++) begin
      tick();
      cyc++;
      if ((which == 1 && frame_done1 === 1'b1) || (which == 3 && frame_done3 === 1'b1))
        seen = 1'b1;
    end
    total++;
    assert (seen) else begin
      bad++;
      $error("FAIL frame_done_timeout ch%0d observed=none required=pulse within %0d", which, bound);
    end
  endtask

  // Monitor for dut1: pop the scoreboard on every transfer, check stall stability.
  initial begin
    exp_t        e;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic [AW-1:0] prev_ri;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_ri    = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          total++;
          assert (out_valid1 === 1'b1 && out_data1 === prev_data && read_index1 === prev_ri) else begin
            bad++;
            $error("FAIL stall_stable observed=v%0b d=%0h ri=%0d expected=v1 d=%0h ri=%0d",
                   out_valid1, out_data1, read_index1, prev_data, prev_ri);
          end
        end
        if (out_valid1 === 1'b1 && out_ready1 === 1'b1) begin
          total++;
          assert (q1.size() > 0) else begin
            bad++;
            $error("FAIL sb1_unexpected observed=%0h expected=no word", out_data1);
          end
          if (q1.size() > 0) begin
            e = q1.pop_front();
            $display("xfer ch1 data=%08h last=%0b (exp %08h/%0b)", out_data1, out_last1, e.data, e.last);
            total++;
            assert (out_data1 === e.data) else begin
              bad++;
              $error("FAIL sb1_data observed=%0h expected=%0h", out_data1, e.data);
            end
            total++;
            assert (out_last1 === e.last) else begin
              bad++;
              $error("FAIL sb1_last observed=%0b expected=%0b", out_last1, e.last);
            end
          end
          xfer1++;
        end
        prev_stall = (out_valid1 === 1'b1) && (out_ready1 !== 1'b1);
        prev_data  = out_data1;
        prev_ri    = read_index1;
      end
    end
  end

  // Monitor for dut3 (RD_LAT=3): data must match the buffer content at its index.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid3 === 1'b1 && out_ready3 === 1'b1) begin
        total++;
        assert (q3.size() > 0) else begin
          bad++;
          $error("FAIL sb3_unexpected observed=%0h expected=no word", out_data3);
        end
        if (q3.size() > 0) begin
          e = q3.pop_front();
          $display("xfer ch3 data=%08h last=%0b (exp %08h/%0b)", out_data3, out_last3, e.data, e.last);
          total++;
          assert (out_data3 === e.data && out_last3 === e.last) else begin
            bad++;
            $error("FAIL sb3_word observed=%0h/%0b expected=%0h/%0b", out_data3, out_last3, e.data, e.last);
          end
        end
        xfer3++;
      end
    end
  end

  initial begin
    int cyc;
    int base;
    bit pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    reset = 1'b1; start1 = 1'b0; start3 = 1'b0; sample_count = '0;
    done_A = 1'b0; done_B = 1'b0; out_ready1 = 1'b1; out_ready3 = 1'b1;
    repeat (3) tick();
    chk("rst_read_index", 32'(read_index1), 32'd0);
    chk("rst_out_data",   out_data1,        32'd0);
    chk("rst_valid_last_busy_fd", {28'd0, out_valid1, out_last1, busy1, frame_done1}, 32'd0);
    reset = 1'b0;
    tick();

    // T1 basic: N=4, dones high, ready high.
    done_A = 1'b1; done_B = 1'b1; sample_count = 10'd4;
    base = xfer1;
    push_frame(1, 4);
    start1 = 1'b1; tick(); start1 = 1'b0;
    chk("t1_busy_after_start", 32'(busy1), 32'd1);
    chk("t1_no_valid_c1", 32'(out_valid1), 32'd0);
    tick();
    chk("t1_no_valid_c2", 32'(out_valid1), 32'd0);
    tick();
    chk("t1_first_valid", 32'(out_valid1), 32'd1);
    chk("t1_first_word", out_data1, 32'h006400C8);
    wait_fd(1, 40, cyc);
    chk("t1_fd_cycles", 32'(cyc), 32'd7);
    chk("t1_xfers", 32'(xfer1 - base), 32'd4);
    chk("t1_busy_in_done", 32'(busy1), 32'd1);
    tick();
    chk("t1_fd_one_cycle", 32'(frame_done1), 32'd0);
    chk("t1_idle", 32'(busy1), 32'd0);

    // T2 backpressure: ready pattern 1,0,0,1.
    sample_count = 10'd3;
    base = xfer1;
    push_frame(1, 3);
    start1 = 1'b1; tick(); start1 = 1'b0;
    for (int k = 0; k < 80; k++) begin
      out_ready1 = pat[k % 4];
      tick();
      if (frame_done1 === 1'b1) break;
    end
    out_ready1 = 1'b1;
    chk("t2_fd_seen", 32'(frame_done1), 32'd1);
    chk("t2_xfers", 32'(xfer1 - base), 32'd3);
    tick();

    // T3 gating: done_B low for 10 cycles after start.
    done_B = 1'b0; sample_count = 10'd2;
    base = xfer1;
    push_frame(1, 2);
    start1 = 1'b1; tick(); start1 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t3_wait_valid", 32'(out_valid1), 32'd0);
      chk("t3_wait_index", 32'(read_index1), 32'd0);
    end
    chk("t3_wait_busy", 32'(busy1), 32'd1);
    done_B = 1'b1;
    wait_fd(1, 40, cyc);
    chk("t3_xfers", 32'(xfer1 - base), 32'd2);
    tick();

    // T4 N=0: immediate frame_done, no words.
    sample_count = 10'd0;
    base = xfer1;
    start1 = 1'b1; tick(); start1 = 1'b0;
    wait_fd(1, 10, cyc);
    chk("t4_n0_fd_cycles", 32'(cyc), 32'd1);
    chk("t4_n0_xfers", 32'(xfer1 - base), 32'd0);
    tick();

    // T4 N=1: single word carrying out_last.
    sample_count = 10'd1;
    base = xfer1;
    push_frame(1, 1);
    start1 = 1'b1; tick(); start1 = 1'b0;
    wait_fd(1, 20, cyc);
    chk("t4_n1_xfers", 32'(xfer1 - base), 32'd1);
    tick();

    // T4 RD_LAT=3 on dut3: N=5, first valid RD_LAT cycles after ARMED.
    sample_count = 10'd5;
    push_frame(3, 5);
    start3 = 1'b1; tick(); start3 = 1'b0;
    tick(); tick(); tick();
    chk("t4_lat3_not_yet", 32'(out_valid3), 32'd0);
    tick();
    chk("t4_lat3_first_valid", 32'(out_valid3), 32'd1);
    wait_fd(3, 60, cyc);
    chk("t4_lat3_xfers", 32'(xfer3), 32'd5);
    tick();

    // T5 reset after the third transfer of an 8-word frame.
    sample_count = 10'd8;
    base = xfer1;
    push_frame(1, 8);
    start1 = 1'b1; tick(); start1 = 1'b0;
    for (int k = 0; k < 60 && (xfer1 - base) < 3; k++) tick();
    chk("t5_three_xfers", 32'(xfer1 - base), 32'd3);
    reset = 1'b1;
    q1.delete();
    tick();
    chk("t5_rst_index", 32'(read_index1), 32'd0);
    chk("t5_rst_data", out_data1, 32'd0);
    chk("t5_rst_ctrl", {28'd0, out_valid1, out_last1, busy1, frame_done1}, 32'd0);
    reset = 1'b0;
    tick();
    sample_count = 10'd2;
    base = xfer1;
    push_frame(1, 2);
    start1 = 1'b1; tick(); start1 = 1'b0;
    wait_fd(1, 30, cyc);
    chk("t5_restart_xfers", 32'(xfer1 - base), 32'd2);
    tick();

    // T6 re-arm: start while busy and in the frame_done cycle are ignored.
    sample_count = 10'd3;
    base = xfer1;
    push_frame(1, 3);
    start1 = 1'b1; tick(); start1 = 1'b0;
    tick(); tick();
    sample_count = 10'd5;
    start1 = 1'b1; tick(); start1 = 1'b0;
    wait_fd(1, 40, cyc);
    chk("t6_xfers_ignoring_start", 32'(xfer1 - base), 32'd3);
    start1 = 1'b1; tick(); start1 = 1'b0;
    chk("t6_start_in_fd_ignored", 32'(busy1), 32'd0);
    sample_count = 10'd1;
    base = xfer1;
    push_frame(1, 1);
    start1 = 1'b1; tick(); start1 = 1'b0;
    chk("t6_new_frame_busy", 32'(busy1), 32'd1);
    wait_fd(1, 20, cyc);
    chk("t6_new_frame_xfers", 32'(xfer1 - base), 32'd1);
    tick();

    chk("sb1_drained", 32'(q1.size()), 32'd0);
    chk("sb3_drained", 32'(q3.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
